ni_inject_scheduler: RTL and testbench
======================================

Name: ni_inject_scheduler

Overview:
- Packet-level round-robin scheduler that shares the NetworkInterface injection path (48-bit flit FIFO) among NUM_REQ local requesters.
- Builds header, body and tail flits for the granted requester and paces writes to one flit per clk_div_8_to_NI rising edge.
- Writes only when the FIFO is not full.
- Sits between the SRAM-side requesters and the NI FIFO write port, replacing the free-running write_enable path.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- NODE_ADDR, 8'h00, source address placed in every header flit.
- FLIT_W, 48, flit width; fixed at 48.

Ports:
- clk  in  1  main clock.
- reset  in  1  synchronous, active-low reset.
- clk_div_8_to_NI  in  1  pacing strobe, sampled synchronously in clk.
- req  in  NUM_REQ  request per requester; level, held until done.
- req_dest  in  NUM_REQ*8  destination address, slice i for requester i.
- req_len  in  NUM_REQ*8  body-flit count 0..255, slice i.
- req_data  in  NUM_REQ*16  current body word, slice i.
- data_ack  out  NUM_REQ  one-cycle pulse when requester i's body word is consumed.
- grant  out  NUM_REQ  one-hot owner of the injection path.
- done  out  NUM_REQ  one-cycle pulse when requester i's tail is written.
- fifo_full  in  1  NI FIFO full flag.
- write_enable  out  1  FIFO write strobe, one cycle.
- flit_out  out  48  flit data, valid when write_enable=1.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Flit format, bits [47:46] are the type: 01 header, 00 body, 10 tail.
  - Header: [45:38]=NODE_ADDR, [37:30]=dest, [29:22]=len, remaining bits 0.
  - Body: [15:0]=data, remaining bits 0.
  - Tail: [15:0]=XOR of all body words (0 if len=0), remaining bits 0.
- Tick: tick = clk_div_8_to_NI & ~clk_div_8_q, where clk_div_8_q is registered.
  - Strobe = tick & ~fifo_full & state in {HEAD, BODY, TAIL}.
  - A tick that coincides with fifo_full is dropped; the same flit retries at the next tick. No tick queuing.
- write_enable equals strobe, combinational from registered state, fifo_full and the tick register. flit_out is combinational from latched fields.
- States: IDLE, HEAD, BODY, TAIL.
  - IDLE: if any req is high, pick the first requester at or after rr_ptr, cyclically.
    - Next cycle: grant is one-hot, dest, len and a count are latched, checksum is cleared, state goes to HEAD.
    - Latency from req to grant: 1 cycle.
  - HEAD: on strobe, write the header. Go to BODY if len>0, else TAIL.
  - BODY: on strobe, write a body flit from req_data[granted].
    - data_ack[granted] pulses in the same cycle; checksum ^= data; count decrements.
    - When count was 1, go to TAIL.
  - TAIL: on strobe, write the tail and pulse done[granted].
    - Next cycle: grant=0, rr_ptr=(granted+1) mod NUM_REQ, state=IDLE.
    - The next arbitration happens the cycle after IDLE is entered; there is no back-to-back grant within that cycle.
- Grant is locked for the whole packet. Deasserting req mid-packet does not abort it. req_dest and req_len are sampled only at grant.
- Reset values (reset=0 at a clk edge): state=IDLE, grant=0, data_ack=0, done=0, write_enable=0, flit_out=0, busy=0, rr_ptr=0, count=0, checksum=0, clk_div_8_q=0.
  - Reset mid-packet abandons the packet with no tail emitted.
- fifo_full asserted continuously stalls indefinitely in the current state; no outputs toggle except via tick.
- Counter is 8 bits with no wrap: len=255 yields 255 body flits, 257 flits total.

Decomposition:
- Package ni_pkg holds:
  - Flit type constants FLIT_HF=2'b01, FLIT_BF=2'b00, FLIT_TF=2'b10.
  - Field bit positions.
  - State enum.
  - A flit-build function.
- Sub-module rr_arbiter (NUM_REQ): inputs req, rr_ptr; outputs one-hot gnt_next and valid; purely combinational priority rotate.

Test Plan:
- Single requester 0: dest=8'h05, len=2, data 16'hAAAA then 16'h5555, fifo_full=0.
  - Flits are 01|00|05|02…, then body AAAA, body 5555, then tail 16'hFFFF.
  - One write per tick, done[0] on the tail.
- req=4'b1111 held, each len=0: grants go 0,1,2,3,0.
  - Each packet is 2 flits (header, then tail with checksum 0).
  - rr_ptr advances after each done.
- fifo_full high across 3 ticks during BODY: no write_enable and no data_ack.
  - After full drops, the next tick writes the same body word and count is unchanged.
- len=255 from requester 2: exactly 255 data_ack pulses and 257 writes.
  - The tail equals the XOR of the data pattern.
- Assert reset=0 during BODY (after 1 of 3 body flits): next cycle all outputs are 0 and state is IDLE.
  - After release with req held, a fresh header is emitted and grant goes to requester 0.
- clk_div_8_to_NI held high for 16 cycles: only one flit is written, proving edge detection.

Source files
------------

// File: rtl/ni_pkg.sv
// -----------------------------------------------------------------------------
// ni_pkg
//   Shared definitions for the NI injection scheduler: flit type codes, flit
//   field positions, scheduler state encoding and a flit assembly helper.
//
//   Flit layout (48 bits):
//     [47:46] type        01 header, 00 body, 10 tail
//     header: [45:38] source node, [37:30] destination, [29:22] body length
//     body  : [15:0]  data word
//     tail  : [15:0]  XOR of every body word of the packet
//     all unused bits are zero
// -----------------------------------------------------------------------------
package ni_pkg;

    localparam logic [1:0] FLIT_HF = 2'b01;
    localparam logic [1:0] FLIT_BF = 2'b00;
    localparam logic [1:0] FLIT_TF = 2'b10;

    localparam int FLIT_TYPE_LSB = 46;
    localparam int FLIT_SRC_LSB  = 38;
    localparam int FLIT_DST_LSB  = 30;
    localparam int FLIT_LEN_LSB  = 22;
    localparam int FLIT_DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    // Header flits carry src/dst/len; body and tail flits carry only the
    // 16-bit data field (payload word or checksum).
    function automatic logic [47:0] build_flit(
        input logic [1:0]  ftype,
        input logic [7:0]  src,
        input logic [7:0]  dst,
        input logic [7:0]  len,
        input logic [15:0] data
    );
        logic [47:0] f;
        f = '0;
        f[FLIT_TYPE_LSB +: 2] = ftype;
        if (ftype == FLIT_HF) begin
            f[FLIT_SRC_LSB +: 8] = src;
            f[FLIT_DST_LSB +: 8] = dst;
            f[FLIT_LEN_LSB +: 8] = len;
        end else begin
            f[FLIT_DATA_LSB +: 16] = data;
        end
        return f;
    endfunction

endpackage

// File: rtl/ni_inject_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational rotating-priority picker. Starting at rr_ptr_i and
//   walking upward (wrapping at NUM_REQ), the first asserted request wins.
//
//   Ports
//     req_i       request vector
//     rr_ptr_i    index that has highest priority this round
//     gnt_next_o  one-hot winner (all zero when nothing requests)
//     gnt_idx_o   binary index of the winner
//     valid_o     at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] gnt_next_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               valid_o
);

    int idx;

    // Walk the offsets from farthest to nearest so the nearest requester,
    // evaluated last, overrides any earlier match.
    always_comb begin
        gnt_next_o = '0;
        gnt_idx_o  = '0;
        valid_o    = 1'b0;
        idx        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_i[idx]) begin
                valid_o         = 1'b1;
                gnt_next_o      = '0;
                gnt_next_o[idx] = 1'b1;
                gnt_idx_o       = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ni_inject_scheduler.sv
// -----------------------------------------------------------------------------
// ni_inject_scheduler
//   Packet-level round-robin scheduler sharing the NI flit FIFO write port
//   among NUM_REQ local requesters. A granted requester owns the path for a
//   whole packet (header, len body flits, tail). At most one flit is written
//   per rising edge of clk_div_8_to_NI, and only while the FIFO is not full.
//
//   Ports
//     clk              main clock
//     reset            synchronous, active-low reset
//     clk_div_8_to_NI  pacing strobe, edge-detected in clk
//     req              per-requester level request, held until done
//     req_dest         8-bit destination per requester (sampled at grant)
//     req_len          8-bit body length per requester (sampled at grant)
//     req_data         16-bit current body word per requester
//     data_ack         pulse: granted requester's body word consumed
//     grant            one-hot owner of the injection path
//     done             pulse: granted requester's tail written
//     fifo_full        NI FIFO full flag
//     write_enable     FIFO write strobe
//     flit_out         flit to write, valid with write_enable
//     busy             a packet is in progress
// -----------------------------------------------------------------------------
module ni_inject_scheduler
    import ni_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter logic [7:0] NODE_ADDR = 8'h00,
    parameter int         FLIT_W    = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_div_8_to_NI,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*8-1:0]  req_dest,
    input  logic [NUM_REQ*8-1:0]  req_len,
    input  logic [NUM_REQ*16-1:0] req_data,
    output logic [NUM_REQ-1:0]    data_ack,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    input  logic                  fifo_full,
    output logic                  write_enable,
    output logic [FLIT_W-1:0]     flit_out,
    output logic                  busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ---------------------------------------------------------------------
    // Per-requester views of the packed request buses
    // ---------------------------------------------------------------------
    logic [7:0]  dest_arr [NUM_REQ];
    logic [7:0]  len_arr  [NUM_REQ];
    logic [15:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign dest_arr[gi] = req_dest[gi*8 +: 8];
            assign len_arr[gi]  = req_len[gi*8 +: 8];
            assign data_arr[gi] = req_data[gi*16 +: 16];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [7:0]           dest_q, dest_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           count_q, count_d;
    logic [15:0]          csum_q, csum_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 clk_div_q;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i      (req),
        .rr_ptr_i   (rr_ptr_q),
        .gnt_next_o (arb_gnt),
        .gnt_idx_o  (arb_idx),
        .valid_o    (arb_valid)
    );

    // ---------------------------------------------------------------------
    // Pacing: one write opportunity per rising edge of the divided clock.
    // A tick lost to fifo_full is not remembered; the same flit waits for
    // the next rising edge.
    // ---------------------------------------------------------------------
    logic tick;
    logic in_pkt;
    logic strobe;
    logic [15:0]       cur_data;
    logic [FLIT_W-1:0] flit_w;

    assign tick     = clk_div_8_to_NI & ~clk_div_q;
    assign in_pkt   = (state_q != ST_IDLE);
    assign strobe   = tick & ~fifo_full & in_pkt;
    assign cur_data = data_arr[gidx_q];

    // ---------------------------------------------------------------------
    // Next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        dest_d   = dest_q;
        len_d    = len_q;
        count_d  = count_q;
        csum_d   = csum_q;
        rr_ptr_d = rr_ptr_q;
        data_ack = '0;
        done     = '0;
        flit_w   = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_HEAD;
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    dest_d  = dest_arr[arb_idx];
                    len_d   = len_arr[arb_idx];
                    count_d = len_arr[arb_idx];
                    csum_d  = '0;
                end
            end

            ST_HEAD: begin
                flit_w = FLIT_W'(build_flit(FLIT_HF, NODE_ADDR, dest_q, len_q, 16'h0000));
                if (strobe) begin
                    state_d = (len_q != 8'd0) ? ST_BODY : ST_TAIL;
                end
            end

            ST_BODY: begin
                flit_w = FLIT_W'(build_flit(FLIT_BF, 8'h00, 8'h00, 8'h00, cur_data));
                data_ack[gidx_q] = strobe;
                if (strobe) begin
                    csum_d  = csum_q ^ cur_data;
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = ST_TAIL;
                    end
                end
            end

            ST_TAIL: begin
                flit_w = FLIT_W'(build_flit(FLIT_TF, 8'h00, 8'h00, 8'h00, csum_q));
                done[gidx_q] = strobe;
                if (strobe) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    // The requester after the one just served gets first
                    // priority next round.
                    rr_ptr_d = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            dest_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            csum_q    <= '0;
            rr_ptr_q  <= '0;
            clk_div_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            dest_q    <= dest_d;
            len_q     <= len_d;
            count_q   <= count_d;
            csum_q    <= csum_d;
            rr_ptr_q  <= rr_ptr_d;
            clk_div_q <= clk_div_8_to_NI;
        end
    end

    assign grant        = grant_q;
    assign write_enable = strobe;
    assign flit_out     = flit_w;
    assign busy         = in_pkt;

endmodule

// File: tb/tb_ni_inject_scheduler.sv
module tb_ni_inject_scheduler;

    localparam int         N    = 4;
    localparam logic [7:0] NODE = 8'h00;

    logic            clk       = 1'b0;
    logic            reset     = 1'b0;
    logic            clk_div   = 1'b0;
    logic            fifo_full = 1'b0;
    logic [N-1:0]    req       = '0;
    logic [N*8-1:0]  req_dest  = '0;
    logic [N*8-1:0]  req_len   = '0;
    logic [N*16-1:0] req_data  = '0;
    logic [N-1:0]    data_ack;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            write_enable;
    logic [47:0]     flit_out;
    logic            busy;

    ni_inject_scheduler #(
        .NUM_REQ   (N),
        .NODE_ADDR (NODE),
        .FLIT_W    (48)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_div_8_to_NI (clk_div),
        .req             (req),
        .req_dest        (req_dest),
        .req_len         (req_len),
        .req_data        (req_data),
        .data_ack        (data_ack),
        .grant           (grant),
        .done            (done),
        .fifo_full       (fifo_full),
        .write_enable    (write_enable),
        .flit_out        (flit_out),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- divided clock and fifo_full generator ----------------
    bit div_run    = 1'b1;
    bit div_level  = 1'b0;
    bit full_rand  = 1'b0;
    bit full_level = 1'b0;
    int div_cnt    = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (div_run) begin
                div_cnt++;
                clk_div = ((div_cnt % 8) >= 4);
            end else begin
                clk_div = div_level;
            end
            fifo_full = full_rand ? ($urandom_range(0, 2) == 0) : full_level;
        end
    end

    // ---------------- requester data and write monitor ----------------
    logic [15:0] words [N][256];
    int          ptr [N];
    logic [47:0] wr_flit [$];
    int          wr_gnt [$];
    longint      wr_cyc [$];
    int          done_idx [$];
    int          ack_cnt  = 0;
    int          done_cnt = 0;
    int          ack_bad  = 0;
    longint      cyc      = 0;

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) ptr[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) req_data[i*16 +: 16] = words[i][ptr[i]];
            #4;
            cyc++;
            if (write_enable) begin
                wr_flit.push_back(flit_out);
                wr_gnt.push_back(onehot_idx(grant));
                wr_cyc.push_back(cyc);
            end
            for (int i = 0; i < N; i++) begin
                if (data_ack[i]) begin
                    ack_cnt++;
                    if (!(write_enable && flit_out[47:46] == 2'b00 && grant[i])) ack_bad++;
                    if (ptr[i] < 255) ptr[i]++;
                end
                if (done[i]) begin
                    done_cnt++;
                    done_idx.push_back(i);
                    ptr[i] = 0;
                end
                if (!req[i]) ptr[i] = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [47:0] exp_flit [$];
    int          exp_gnt [$];
    int          model_ptr = 0;

    task automatic model_packet(input int g, input logic [7:0] dest, input int len);
        logic [15:0] x;
        x = 16'h0000;
        exp_flit.push_back({2'b01, NODE, dest, 8'(len), 22'd0});
        exp_gnt.push_back(g);
        for (int k = 0; k < len; k++) begin
            exp_flit.push_back({32'd0, words[g][k]});
            exp_gnt.push_back(g);
            x = x ^ words[g][k];
        end
        exp_flit.push_back({2'b10, 30'd0, x});
        exp_gnt.push_back(g);
    endtask

    function automatic int pick_rr(input logic [N-1:0] pend, input int p);
        for (int k = 0; k < N; k++) if (pend[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_done(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic wait_ack(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (ack_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (ack_cnt >= target);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (grant !== '0)        begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
        n_checks++; if (data_ack !== '0)     begin n_fail++; $display("FAIL reset_ack: got %b want 0", data_ack); end
        n_checks++; if (done !== '0)         begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (write_enable !== 0)  begin n_fail++; $display("FAIL reset_we: got %b want 0", write_enable); end
        n_checks++; if (flit_out !== '0)     begin n_fail++; $display("FAIL reset_flit: got %h want 0", flit_out); end
        n_checks++; if (busy !== 0)          begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1;
        model_ptr = 0;
        repeat (2) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        int base, d0, db;
        bit ok;
        logic [N-1:0] pend;
        exp_flit.delete(); exp_gnt.delete();
        base = wr_flit.size(); d0 = done_cnt; db = done_idx.size();
        for (int i = 0; i < N; i++) begin
            req_dest[i*8 +: 8] = 8'($urandom);
            req_len[i*8 +: 8]  = 8'd0;
        end
        pend = '1;
        for (int p = 0; p < 5; p++) begin
            int g;
            g = pick_rr(pend, model_ptr);
            model_packet(g, req_dest[g*8 +: 8], 0);
            model_ptr = (g + 1) % N;
        end
        req = '1;
        wait_done(d0 + 5, 600, ok);
        req = '0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d dones want %0d", done_cnt - d0, 5); end
        for (int k = 0; k < exp_flit.size(); k++) begin
            n_checks++;
            if (base + k >= wr_flit.size()) begin
                n_fail++; $display("FAIL rr_flit[%0d]: got nothing want %h", k, exp_flit[k]);
            end else if (wr_flit[base+k] !== exp_flit[k] || wr_gnt[base+k] != exp_gnt[k]) begin
                n_fail++; $display("FAIL rr_flit[%0d]: got %h grant %0d want %h grant %0d", k, wr_flit[base+k], wr_gnt[base+k], exp_flit[k], exp_gnt[k]);
            end
        end
        for (int p = 0; p < 5; p++) begin
            n_checks++;
            if (db + p >= done_idx.size() || done_idx[db+p] != exp_gnt[2*p]) begin
                n_fail++; $display("FAIL rr_done[%0d]: got %0d want %0d", p, (db + p < done_idx.size()) ? done_idx[db+p] : -1, exp_gnt[2*p]);
            end
        end
        repeat (3) @(negedge clk);
        $display("test_round_robin: %0d packets", 5);
    endtask

    task automatic test_single();
        int base, d0, a0;
        bit ok;
        exp_flit.delete(); exp_gnt.delete();
        base = wr_flit.size(); d0 = done_cnt; a0 = ack_cnt;
        words[0][0] = 16'hAAAA;
        words[0][1] = 16'h5555;
        req_dest[7:0] = 8'h05;
        req_len[7:0]  = 8'd2;
        model_packet(0, 8'h05, 2);
        model_ptr = 1;
        req[0] = 1'b1;
        wait_done(d0 + 1, 300, ok);
        req[0] = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d dones want 1", done_cnt - d0); end
        n_checks++; if (exp_flit[3] !== 48'h8000_0000_FFFF) begin n_fail++; $display("FAIL single_model_tail: got %h want 8000_0000_ffff", exp_flit[3]); end
        for (int k = 0; k < exp_flit.size(); k++) begin
            n_checks++;
            if (base + k >= wr_flit.size()) begin
                n_fail++; $display("FAIL single_flit[%0d]: got nothing want %h", k, exp_flit[k]);
            end else if (wr_flit[base+k] !== exp_flit[k] || wr_gnt[base+k] != 0) begin
                n_fail++; $display("FAIL single_flit[%0d]: got %h grant %0d want %h grant 0", k, wr_flit[base+k], wr_gnt[base+k], exp_flit[k]);
            end
        end
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (base + k >= wr_cyc.size() || wr_cyc[base+k] - wr_cyc[base+k-1] != 8) begin
                n_fail++; $display("FAIL single_spacing[%0d]: got gap %0d want 8", k, (base + k < wr_cyc.size()) ? wr_cyc[base+k] - wr_cyc[base+k-1] : -1);
            end
        end
        n_checks++; if (ack_cnt - a0 != 2) begin n_fail++; $display("FAIL single_acks: got %0d want 2", ack_cnt - a0); end
        n_checks++; if (ack_bad != 0) begin n_fail++; $display("FAIL single_ack_timing: got %0d stray acks want 0", ack_bad); end
        repeat (3) @(negedge clk);
        $display("test_single: %0d flits", wr_flit.size() - base);
    endtask

    task automatic test_fifo_full();
        int base, d0, a0, w_hold, a_hold;
        bit ok;
        exp_flit.delete(); exp_gnt.delete();
        base = wr_flit.size(); d0 = done_cnt; a0 = ack_cnt;
        for (int k = 0; k < 3; k++) words[1][k] = 16'($urandom);
        req_dest[15:8] = 8'($urandom);
        req_len[15:8]  = 8'd3;
        model_packet(1, req_dest[15:8], 3);
        model_ptr = 2;
        req[1] = 1'b1;
        wait_ack(a0 + 1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_first_ack: got %0d acks want 1", ack_cnt - a0); end
        full_level = 1'b1;
        @(negedge clk);
        w_hold = wr_flit.size(); a_hold = ack_cnt;
        repeat (26) @(negedge clk);
        n_checks++; if (wr_flit.size() != w_hold) begin n_fail++; $display("FAIL full_no_write: got %0d writes want 0", wr_flit.size() - w_hold); end
        n_checks++; if (ack_cnt != a_hold) begin n_fail++; $display("FAIL full_no_ack: got %0d acks want 0", ack_cnt - a_hold); end
        full_level = 1'b0;
        wait_done(d0 + 1, 300, ok);
        req[1] = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout: got %0d dones want 1", done_cnt - d0); end
        for (int k = 0; k < exp_flit.size(); k++) begin
            n_checks++;
            if (base + k >= wr_flit.size()) begin
                n_fail++; $display("FAIL full_flit[%0d]: got nothing want %h", k, exp_flit[k]);
            end else if (wr_flit[base+k] !== exp_flit[k] || wr_gnt[base+k] != 1) begin
                n_fail++; $display("FAIL full_flit[%0d]: got %h want %h", k, wr_flit[base+k], exp_flit[k]);
            end
        end
        n_checks++; if (wr_flit.size() - base != 5) begin n_fail++; $display("FAIL full_count: got %0d writes want 5", wr_flit.size() - base); end
        repeat (3) @(negedge clk);
        $display("test_fifo_full: %0d flits", wr_flit.size() - base);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [N-1:0] set, pend;
            int base, d0, a0, db, cnt, exp_acks, len, g;
            int exp_done [$];
            bit ok;
            exp_flit.delete(); exp_gnt.delete();
            set = N'($urandom_range(1, (1 << N) - 1));
            base = wr_flit.size(); d0 = done_cnt; a0 = ack_cnt; db = done_idx.size();
            cnt = $countones(set); exp_acks = 0; pend = set;
            for (int i = 0; i < N; i++) begin
                if (set[i]) begin
                    len = $urandom_range(0, 6);
                    req_dest[i*8 +: 8] = 8'($urandom);
                    req_len[i*8 +: 8]  = 8'(len);
                    for (int k = 0; k < len; k++) words[i][k] = 16'($urandom);
                end
            end
            for (int p = 0; p < cnt; p++) begin
                g = pick_rr(pend, model_ptr);
                pend[g] = 1'b0;
                model_packet(g, req_dest[g*8 +: 8], int'(req_len[g*8 +: 8]));
                exp_acks += int'(req_len[g*8 +: 8]);
                exp_done.push_back(g);
                model_ptr = (g + 1) % N;
            end
            full_rand = 1'b1;
            req = set;
            for (int p = 0; p < cnt; p++) begin
                wait_done(d0 + p + 1, 600, ok);
                if (ok) req[done_idx[done_idx.size()-1]] = 1'b0;
                else req = '0;
            end
            full_rand = 1'b0;
            n_checks++; if (done_cnt - d0 != cnt) begin n_fail++; $display("FAIL rand%0d_dones: got %0d want %0d", r, done_cnt - d0, cnt); end
            for (int k = 0; k < exp_flit.size(); k++) begin
                n_checks++;
                if (base + k >= wr_flit.size()) begin
                    n_fail++; $display("FAIL rand%0d_flit[%0d]: got nothing want %h", r, k, exp_flit[k]);
                end else if (wr_flit[base+k] !== exp_flit[k] || wr_gnt[base+k] != exp_gnt[k]) begin
                    n_fail++; $display("FAIL rand%0d_flit[%0d]: got %h grant %0d want %h grant %0d", r, k, wr_flit[base+k], wr_gnt[base+k], exp_flit[k], exp_gnt[k]);
                end
            end
            for (int p = 0; p < cnt; p++) begin
                n_checks++;
                if (db + p >= done_idx.size() || done_idx[db+p] != exp_done[p]) begin
                    n_fail++; $display("FAIL rand%0d_done[%0d]: want %0d", r, p, exp_done[p]);
                end
            end
            n_checks++; if (ack_cnt - a0 != exp_acks) begin n_fail++; $display("FAIL rand%0d_acks: got %0d want %0d", r, ack_cnt - a0, exp_acks); end
            repeat (3) @(negedge clk);
            $display("test_random round %0d: set=%b packets=%0d flits=%0d", r, set, cnt, exp_flit.size());
        end
        n_checks++; if (ack_bad != 0) begin n_fail++; $display("FAIL rand_ack_timing: got %0d stray acks want 0", ack_bad); end
    endtask

    task automatic test_len255();
        int base, d0, a0;
        bit ok;
        exp_flit.delete(); exp_gnt.delete();
        base = wr_flit.size(); d0 = done_cnt; a0 = ack_cnt;
        for (int k = 0; k < 255; k++) words[2][k] = 16'($urandom);
        req_dest[23:16] = 8'($urandom);
        req_len[23:16]  = 8'd255;
        model_packet(2, req_dest[23:16], 255);
        model_ptr = 3;
        req[2] = 1'b1;
        wait_done(d0 + 1, 3000, ok);
        req[2] = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL len255_timeout: got %0d dones want 1", done_cnt - d0); end
        n_checks++; if (ack_cnt - a0 != 255) begin n_fail++; $display("FAIL len255_acks: got %0d want 255", ack_cnt - a0); end
        n_checks++; if (wr_flit.size() - base != 257) begin n_fail++; $display("FAIL len255_writes: got %0d want 257", wr_flit.size() - base); end
        for (int k = 0; k < exp_flit.size(); k++) begin
            n_checks++;
            if (base + k >= wr_flit.size()) begin
                n_fail++; $display("FAIL len255_flit[%0d]: got nothing want %h", k, exp_flit[k]);
            end else if (wr_flit[base+k] !== exp_flit[k]) begin
                n_fail++; $display("FAIL len255_flit[%0d]: got %h want %h", k, wr_flit[base+k], exp_flit[k]);
            end
        end
        repeat (3) @(negedge clk);
        $display("test_len255: %0d flits tail=%h", wr_flit.size() - base, exp_flit[256]);
    endtask

    task automatic test_reset_mid();
        int base, d0, a0, db, n;
        bit ok;
        logic [47:0] exp_hdr;
        d0 = done_cnt; a0 = ack_cnt;
        for (int k = 0; k < 8; k++) words[0][k] = 16'($urandom);
        req_dest[7:0] = 8'($urandom);
        req_len[7:0]  = 8'd3;
        req_dest[15:8] = 8'($urandom);
        req_len[15:8]  = 8'd1;
        req[0] = 1'b1;
        wait_ack(a0 + 1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_first_ack: got %0d acks want 1", ack_cnt - a0); end
        req[1] = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== '0)       begin n_fail++; $display("FAIL rmid_grant: got %b want 0", grant); end
        n_checks++; if (data_ack !== '0)    begin n_fail++; $display("FAIL rmid_ack: got %b want 0", data_ack); end
        n_checks++; if (done !== '0)        begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
        n_checks++; if (write_enable !== 0) begin n_fail++; $display("FAIL rmid_we: got %b want 0", write_enable); end
        n_checks++; if (flit_out !== '0)    begin n_fail++; $display("FAIL rmid_flit: got %h want 0", flit_out); end
        n_checks++; if (busy !== 0)         begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        reset = 1'b1;
        model_ptr = 0;
        base = wr_flit.size(); db = done_idx.size();
        exp_hdr = {2'b01, NODE, req_dest[7:0], 8'd3, 22'd0};
        n = 0;
        while (wr_flit.size() <= base && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (wr_flit.size() <= base) begin
            n_fail++; $display("FAIL rmid_header: got nothing want %h", exp_hdr);
        end else if (wr_flit[base] !== exp_hdr || wr_gnt[base] != 0) begin
            n_fail++; $display("FAIL rmid_header: got %h grant %0d want %h grant 0", wr_flit[base], wr_gnt[base], exp_hdr);
        end
        for (int p = 0; p < 2; p++) begin
            wait_done(d0 + p + 1, 400, ok);
            if (ok) req[done_idx[done_idx.size()-1]] = 1'b0;
            else req = '0;
        end
        n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL rmid_dones: got %0d want 2", done_cnt - d0); end
        n_checks++;
        if (done_idx.size() < db + 2 || done_idx[db] != 0 || done_idx[db+1] != 1) begin
            n_fail++; $display("FAIL rmid_order: got %0d dones after reset, want requester 0 then 1", done_idx.size() - db);
        end
        model_ptr = 2;
        repeat (3) @(negedge clk);
        $display("test_reset_mid: header %h", exp_hdr);
    endtask

    task automatic test_div_held();
        int base, d0;
        bit ok;
        exp_flit.delete(); exp_gnt.delete();
        d0 = done_cnt;
        div_run = 1'b0; div_level = 1'b0;
        repeat (3) @(negedge clk);
        req_dest[7:0] = 8'($urandom);
        req_len[7:0]  = 8'd0;
        model_packet(0, req_dest[7:0], 0);
        req[0] = 1'b1;
        repeat (4) @(negedge clk);
        base = wr_flit.size();
        div_level = 1'b1;
        repeat (16) @(negedge clk);
        n_checks++; if (wr_flit.size() - base != 1) begin n_fail++; $display("FAIL div_held_writes: got %0d want 1", wr_flit.size() - base); end
        div_level = 1'b0;
        repeat (2) @(negedge clk);
        div_run = 1'b1;
        wait_done(d0 + 1, 100, ok);
        req[0] = 1'b0;
        model_ptr = 1;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL div_held_timeout: got %0d dones want 1", done_cnt - d0); end
        for (int k = 0; k < exp_flit.size(); k++) begin
            n_checks++;
            if (base + k >= wr_flit.size()) begin
                n_fail++; $display("FAIL div_flit[%0d]: got nothing want %h", k, exp_flit[k]);
            end else if (wr_flit[base+k] !== exp_flit[k]) begin
                n_fail++; $display("FAIL div_flit[%0d]: got %h want %h", k, wr_flit[base+k], exp_flit[k]);
            end
        end
        repeat (3) @(negedge clk);
        $display("test_div_held: %0d flits", wr_flit.size() - base);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_fifo_full();
        test_random();
        test_len255();
        test_reset_mid();
        test_div_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
